// File: rtl/sensor_alarm.sv
// Debounced sensor fault alarm with operator acknowledge, fault-code snapshot
// and a saturating alarm-event counter.
module sensor_alarm #(
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       error,
  input  logic [3:0] sensors,
  input  logic       ack,
  input  logic       count_clr,
  output logic       alarm,
  output logic [3:0] alarm_code,
  output logic [7:0] err_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, QUALIFY, ALARM, CLEAR} state_t;

  state_t     state, state_n;
  logic [3:0] qcnt, qcnt_n;
  logic [4:0] qcnt_inc;
  logic       enter;
  logic       alarm_n;
  logic [3:0] code_n;
  logic [7:0] count_n;

  assign qcnt_inc = {1'b0, qcnt} + 5'd1;

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    alarm_n = alarm;
    enter   = 1'b0;
    case (state)
      IDLE: begin
        if (error) begin
          if (DEBOUNCE == 1) begin
            state_n = ALARM;
            qcnt_n  = '0;
            enter   = 1'b1;
          end else begin
            state_n = QUALIFY;
            qcnt_n  = 4'd1;
          end
        end else begin
          qcnt_n = '0;
        end
      end
      QUALIFY: begin
        if (!error) begin
          state_n = IDLE;
          qcnt_n  = '0;
        end else if (qcnt_inc < 5'(DEBOUNCE)) begin
          qcnt_n = qcnt_inc[3:0];
        end else begin
          state_n = ALARM;
          qcnt_n  = '0;
          enter   = 1'b1;
        end
      end
      ALARM: begin
        // A persisting fault parks in CLEAR so it cannot re-qualify.
        if (ack) begin
          state_n = error ? CLEAR : IDLE;
          alarm_n = 1'b0;
        end
      end
      CLEAR: begin
        if (!error) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (enter) alarm_n = 1'b1;
    code_n = enter ? sensors : alarm_code;

    // Entry with a simultaneous clear counts this event only.
    if (enter) begin
      if (count_clr)               count_n = 8'd1;
      else if (err_count == '1)    count_n = err_count;
      else                         count_n = err_count + 8'd1;
    end else if (count_clr) begin
      count_n = '0;
    end else begin
      count_n = err_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      qcnt       <= '0;
      alarm      <= 1'b0;
      alarm_code <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      qcnt       <= qcnt_n;
      alarm      <= alarm_n;
      alarm_code <= code_n;
      err_count  <= count_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_sensor_alarm.sv
// Directed bench for sensor_alarm: a vector table on a DEBOUNCE=3 instance,
// plus hand sequences for saturation, reset requalification and DEBOUNCE=1.
module tb_sensor_alarm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, error, ack, count_clr;
  logic [3:0] sensors;
  logic       alarm;
  logic [3:0] alarm_code;
  logic [7:0] err_count;
  logic       busy;

  logic       r1, e1, a1, c1;
  logic [3:0] s1;
  logic       alarm1;
  logic [3:0] code1;
  logic [7:0] count1;
  logic       busy1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  sensor_alarm #(.DEBOUNCE(3)) dut3 (
    .clk(clk), .rst(rst), .error(error), .sensors(sensors), .ack(ack),
    .count_clr(count_clr), .alarm(alarm), .alarm_code(alarm_code),
    .err_count(err_count), .busy(busy)
  );

  sensor_alarm #(.DEBOUNCE(1)) dut1 (
    .clk(clk), .rst(r1), .error(e1), .sensors(s1), .ack(a1),
    .count_clr(c1), .alarm(alarm1), .alarm_code(code1),
    .err_count(count1), .busy(busy1)
  );

  typedef struct {
    logic       rst;
    logic       error;
    logic [3:0] sensors;
    logic       ack;
    logic       count_clr;
    logic       e_alarm;
    logic [3:0] e_code;
    logic [7:0] e_count;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [3:0] s,
                              input logic a, input logic c, input logic ea,
                              input logic [3:0] ec, input logic [7:0] en, input logic eb);
    vec_t v;
    v.rst = r; v.error = e; v.sensors = s; v.ack = a; v.count_clr = c;
    v.e_alarm = ea; v.e_code = ec; v.e_count = en; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic ga, input logic [3:0] gc,
                       input logic [7:0] gn, input logic gb, input logic ea,
                       input logic [3:0] ec, input logic [7:0] en, input logic eb);
    tests++;
    if ({ga, gc, gn, gb} !== {ea, ec, en, eb}) begin
      fails++;
      $display("FAIL %s: got alarm=%0b code=%h count=%0d busy=%0b, expected alarm=%0b code=%h count=%0d busy=%0b",
               name, ga, gc, gn, gb, ea, ec, en, eb);
    end
  endtask

  task automatic step3(input logic r, input logic e, input logic [3:0] s,
                       input logic a, input logic c);
    rst = r; error = e; sensors = s; ack = a; count_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic e, input logic [3:0] s,
                       input logic a, input logic c);
    r1 = r; e1 = e; s1 = s; a1 = a; c1 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned model;

    rst = 1'b1; error = 1'b0; sensors = '0; ack = 1'b0; count_clr = 1'b0;
    r1  = 1'b1; e1 = 1'b0; s1 = '0; a1 = 1'b0; c1 = 1'b0;

    //   rst err sens  ack clr | alarm code cnt busy
    add(1, 0, 4'h0, 0, 0,  0, 4'h0, 0, 0);
    add(1, 1, 4'hF, 1, 1,  0, 4'h0, 0, 0);
    add(0, 1, 4'h6, 0, 0,  0, 4'h0, 0, 1);
    add(0, 1, 4'h6, 0, 0,  0, 4'h0, 0, 1);
    add(0, 1, 4'h6, 0, 0,  1, 4'h6, 1, 1);
    add(0, 0, 4'hF, 0, 0,  1, 4'h6, 1, 1);
    add(0, 0, 4'hF, 1, 0,  0, 4'h6, 1, 0);
    add(0, 1, 4'hA, 0, 0,  0, 4'h6, 1, 1);
    add(0, 1, 4'hA, 0, 0,  0, 4'h6, 1, 1);
    add(0, 0, 4'hA, 0, 0,  0, 4'h6, 1, 0);
    add(0, 1, 4'hA, 0, 0,  0, 4'h6, 1, 1);
    add(0, 1, 4'hA, 0, 0,  0, 4'h6, 1, 1);
    add(0, 0, 4'hA, 0, 0,  0, 4'h6, 1, 0);
    add(0, 0, 4'hA, 1, 0,  0, 4'h6, 1, 0);
    add(0, 1, 4'h9, 0, 0,  0, 4'h6, 1, 1);
    add(0, 1, 4'h9, 1, 0,  0, 4'h6, 1, 1);
    add(0, 1, 4'h9, 1, 0,  1, 4'h9, 2, 1);
    add(0, 1, 4'h2, 0, 0,  1, 4'h9, 2, 1);
    add(0, 1, 4'h2, 1, 0,  0, 4'h9, 2, 1);
    add(0, 1, 4'h2, 0, 0,  0, 4'h9, 2, 1);
    add(0, 1, 4'h2, 1, 0,  0, 4'h9, 2, 1);
    add(0, 1, 4'h2, 0, 0,  0, 4'h9, 2, 1);
    add(0, 0, 4'h2, 0, 0,  0, 4'h9, 2, 0);
    add(0, 1, 4'h3, 0, 0,  0, 4'h9, 2, 1);
    add(0, 1, 4'h3, 0, 0,  0, 4'h9, 2, 1);
    add(0, 1, 4'h3, 0, 0,  1, 4'h3, 3, 1);
    add(0, 0, 4'h7, 0, 1,  1, 4'h3, 0, 1);
    add(0, 0, 4'h7, 1, 0,  0, 4'h3, 0, 0);
    add(0, 1, 4'h4, 0, 0,  0, 4'h3, 0, 1);
    add(0, 1, 4'h4, 0, 0,  0, 4'h3, 0, 1);
    add(1, 1, 4'h4, 1, 1,  0, 4'h0, 0, 0);
    add(0, 1, 4'h5, 0, 0,  0, 4'h0, 0, 1);
    add(0, 1, 4'h5, 0, 0,  0, 4'h0, 0, 1);
    add(0, 1, 4'h5, 0, 0,  1, 4'h5, 1, 1);
    add(0, 0, 4'h5, 1, 0,  0, 4'h5, 1, 0);

    foreach (vecs[i]) begin
      step3(vecs[i].rst, vecs[i].error, vecs[i].sensors, vecs[i].ack, vecs[i].count_clr);
      check($sformatf("vec%0d", i), alarm, alarm_code, err_count, busy,
            vecs[i].e_alarm, vecs[i].e_code, vecs[i].e_count, vecs[i].e_busy);
    end

    // Reset while alarmed with count 5, fault held through and after reset.
    step3(1, 0, 4'h0, 0, 0);
    for (int unsigned n = 1; n <= 5; n++) begin
      step3(0, 1, 4'hC, 0, 0);
      step3(0, 1, 4'hC, 0, 0);
      step3(0, 1, 4'hC, 0, 0);
      if (n < 5) step3(0, 0, 4'hC, 1, 0);
    end
    check("alarm_cnt5", alarm, alarm_code, err_count, busy, 1'b1, 4'hC, 8'd5, 1'b1);
    step3(1, 1, 4'hC, 0, 0);
    check("rst_in_alarm", alarm, alarm_code, err_count, busy, 1'b0, 4'h0, 8'd0, 1'b0);
    step3(0, 1, 4'hC, 0, 0);
    check("requal_1", alarm, alarm_code, err_count, busy, 1'b0, 4'h0, 8'd0, 1'b1);
    step3(0, 1, 4'hC, 0, 0);
    check("requal_2", alarm, alarm_code, err_count, busy, 1'b0, 4'h0, 8'd0, 1'b1);
    step3(0, 1, 4'hD, 0, 0);
    check("requal_3", alarm, alarm_code, err_count, busy, 1'b1, 4'hD, 8'd1, 1'b1);
    step3(0, 0, 4'h0, 1, 0);

    // Saturation: 260 acknowledged alarms, then clear coinciding with entry.
    step3(1, 0, 4'h0, 0, 0);
    for (int unsigned n = 1; n <= 260; n++) begin
      logic [3:0] s;
      s = 4'(n);
      model = (n > 255) ? 255 : n;
      step3(0, 1, s, 0, 0);
      step3(0, 1, s, 0, 0);
      step3(0, 1, s, 0, 0);
      check($sformatf("sat%0d", n), alarm, alarm_code, err_count, busy,
            1'b1, s, 8'(model), 1'b1);
      step3(0, 0, 4'h0, 1, 0);
    end
    step3(0, 1, 4'hE, 0, 0);
    step3(0, 1, 4'hE, 0, 0);
    step3(0, 1, 4'hE, 0, 1);
    check("clr_at_entry", alarm, alarm_code, err_count, busy, 1'b1, 4'hE, 8'd1, 1'b1);
    step3(0, 0, 4'h0, 1, 0);

    // DEBOUNCE=1: single-cycle fault alarms at once; same-edge ack ignored.
    step1(1, 1, 4'hF, 1, 1);
    check("d1_reset", alarm1, code1, count1, busy1, 1'b0, 4'h0, 8'd0, 1'b0);
    step1(0, 1, 4'h1, 1, 0);
    check("d1_entry", alarm1, code1, count1, busy1, 1'b1, 4'h1, 8'd1, 1'b1);
    step1(0, 0, 4'hF, 0, 0);
    check("d1_hold", alarm1, code1, count1, busy1, 1'b1, 4'h1, 8'd1, 1'b1);
    step1(0, 0, 4'hF, 1, 0);
    check("d1_ack", alarm1, code1, count1, busy1, 1'b0, 4'h1, 8'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sensor_alarm.md
SENSOR_ALARM -- requirements
Module: sensor_alarm

Interface
REQ-001 Parameter: DEBOUNCE, default 3, consecutive high `error` samples needed to raise an alarm; legal range 1..15.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: error  input  1  fault flag from the sensor error detector; sampled every clk edge.
REQ-005 Port: sensors  input  4  raw sensor vector that produced `error`; snapshotted at alarm.
REQ-006 Port: ack  input  1  operator acknowledge; one-cycle or level pulse.
REQ-007 Port: count_clr  input  1  synchronous clear of the event counter.
REQ-008 Port: alarm  output  1  registered alarm flag.
REQ-009 Port: alarm_code  output  4  registered snapshot of `sensors` at alarm entry.
REQ-010 Port: err_count  output  8  registered, saturating count of alarm events.
REQ-011 Port: busy  output  1  registered; high in QUALIFY, ALARM and CLEAR.

Function
REQ-012 The block SHALL implement an FSM with the states IDLE, QUALIFY, ALARM and CLEAR, plus a 4-bit qualify counter `qcnt`.
REQ-013 IDLE: on `error`=1, if DEBOUNCE=1, SHALL enter ALARM directly; otherwise SHALL enter QUALIFY with qcnt=1; on `error`=0 SHALL stay in IDLE with qcnt=0.
REQ-014 QUALIFY: on `error`=0, SHALL return to IDLE with qcnt=0, with no alarm and no count change.
REQ-015 QUALIFY: on `error`=1 with qcnt+1 < DEBOUNCE, SHALL increment qcnt and stay in QUALIFY.
REQ-016 QUALIFY: on `error`=1 with qcnt+1 = DEBOUNCE, SHALL enter ALARM.
REQ-017 Alarm entry latency: if `error` is first high at edge t, `alarm` SHALL be 1 in the cycle after edge t+DEBOUNCE-1.
REQ-018 On ALARM entry, at the same edge, the block SHALL set alarm=1, SHALL load alarm_code with `sensors` sampled at that edge, and SHALL increment err_count.
REQ-019 err_count SHALL saturate at 255 and SHALL never wrap to 0.
REQ-020 ALARM: `alarm` and `alarm_code` SHALL hold while ack=0, regardless of `error`.
REQ-021 ALARM: on ack=1 with `error`=0, SHALL go to IDLE with alarm=0.
REQ-022 ALARM: on ack=1 with `error`=1, SHALL go to CLEAR with alarm=0.
REQ-023 CLEAR: SHALL stay while `error`=1 and SHALL go to IDLE on the first edge with `error`=0; the persisting fault SHALL NOT re-trigger an alarm.
REQ-024 `ack` SHALL be ignored in IDLE, QUALIFY and CLEAR.
REQ-025 `ack` asserted at the same edge as ALARM entry SHALL be ignored; acknowledge takes effect from the next edge.
REQ-026 alarm_code SHALL retain its last value after acknowledge until the next ALARM entry.
REQ-027 count_clr=1 SHALL set err_count=0 at the next edge.
REQ-028 If count_clr=1 coincides with an ALARM entry, err_count SHALL become 1.
REQ-029 busy SHALL equal (state != IDLE), registered together with the state.
REQ-030 All outputs SHALL be driven from flops; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-031 While rst=1 at a clk edge: state=IDLE, qcnt=0, alarm=0, alarm_code=4'b0000, err_count=0, busy=0.
REQ-032 Reset SHALL override every other input, including ack, count_clr and error.
REQ-033 Reset mid-QUALIFY or mid-ALARM SHALL discard the pending or active alarm and the count.
REQ-034 After rst drops, a fault already held high SHALL require a full DEBOUNCE qualification before any alarm.

Verification
REQ-035 DEBOUNCE=3, sensors=4'b0110, error high 3 cycles from edge 0 -> alarm=1 after edge 2, alarm_code=4'b0110, err_count=1, busy=1.
REQ-036 DEBOUNCE=3, error pattern 1,1,0,1,1,0 -> alarm never asserted, err_count=0, FSM back in IDLE.
REQ-037 In ALARM with error held at 1, ack pulse -> alarm=0, state CLEAR, no new alarm while error stays 1; error 0 for one edge -> IDLE; error 1 for 3 further cycles -> new alarm, err_count=2.
REQ-038 Force 256 qualified alarms, each acknowledged -> err_count stays 255; count_clr together with the next ALARM entry -> err_count=1.
REQ-039 rst=1 while alarm=1 and err_count=5 -> next cycle alarm=0, err_count=0, alarm_code=0; with error held high, alarm rises only after 3 further qualifying edges.
REQ-040 DEBOUNCE=1, single-cycle error with sensors=4'b0001 -> alarm=1 after that edge, alarm_code=4'b0001; ack at that same edge is ignored, and alarm stays 1.
